dds_phase_generator: RTL and testbench
======================================

Name: dds_phase_generator

Overview:
Phase-accumulator front end of the DDS core. Drives the 14-bit phase address into the waveform ROMs (square/sine/etc.) and produces a sample strobe aligned to the ROM read latency. Supports a frequency tuning word (FTW) load handshake, an optional phase-continuous load deferred to the next accumulator wrap, a phase offset, and a programmable sample-rate divider.

Parameters:
ACC_W, 32, accumulator width in bits
PHASE_W, 14, output phase width; the phase is the top PHASE_W bits of the accumulator
DIV_W, 16, sample divider width
ROM_LAT, 1, waveform ROM read latency in clocks; value_valid is delayed by this amount

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous, active-low reset
enable  in  1  run/hold; 0 freezes the accumulator
sample_div  in  DIV_W  tick every sample_div+1 clocks
ftw_in  in  ACC_W  new tuning word
ftw_sync  in  1  1 = apply at next wrap, 0 = apply immediately
ftw_valid  in  1  FTW load request
ftw_ready  out  1  FTW load accepted when ftw_valid & ftw_ready
poff_in  in  PHASE_W  phase offset
poff_valid  in  1  latch poff_in
phase  out  PHASE_W  ROM address, registered
phase_valid  out  1  1-clock pulse when phase updates
value_valid  out  1  phase_valid delayed ROM_LAT clocks; marks valid ROM output
wrap  out  1  1-clock pulse coincident with phase_valid when the accumulator carried out

Behaviour:
- Reset (rst=0, asynchronous): acc=0, ftw_active=0, ftw_pend=0, poff_active=0, div_cnt=0, phase=0, phase_valid=0, value_valid pipeline=0, wrap=0, FSM=IDLE (ftw_ready=1). Reset asserted mid-operation clears everything immediately, including a pending FTW.
- Divider: when enable=1, div_cnt increments; tick=(div_cnt==sample_div), and div_cnt returns to 0 on tick. sample_div=0 gives tick every clock. When enable=0, div_cnt is held at 0 and tick=0. A sample_div change takes effect on the next compare. If div_cnt>sample_div after a change, div_cnt wraps naturally through 2^DIV_W.
- Accumulate on tick:
  - {carry, acc} <= acc + ftw_active, computed at ACC_W+1 bits.
  - phase <= (acc+ftw_active)[ACC_W-1 -: PHASE_W] + poff_active, modulo 2^PHASE_W.
  - phase_valid <= 1; wrap <= carry.
- No tick: phase holds; phase_valid=0; wrap=0.
- Latency: phase/phase_valid registered one clock after the tick cycle. value_valid is a ROM_LAT-deep shift of phase_valid.
- FTW FSM:
  - IDLE: ftw_ready=1.
    - On ftw_valid with ftw_sync=0: ftw_active <= ftw_in; stay IDLE.
    - On ftw_valid with ftw_sync=1: ftw_pend <= ftw_in; go to PENDING.
  - PENDING: ftw_ready=0. On a tick where carry=1: ftw_active <= ftw_pend; go to IDLE.
- FTW timing:
  - The accumulate in the same cycle as any FTW update uses the old ftw_active.
  - The new word affects the following tick.
  - enable=0 while PENDING: the pending word is retained.
- Phase offset: poff_valid latches poff_active <= poff_in. It takes effect on the next tick; the accumulator is not disturbed.
- ftw_active=0 with enable=1: phase = acc top bits + poff, constant. phase_valid still pulses each tick; wrap stays 0.

Test Plan:
1. Hold rst=0, then release -> phase=0, phase_valid=0, value_valid=0, wrap=0, ftw_ready=1. Assert rst mid-run with a PENDING load -> all outputs 0 and ftw_ready=1 immediately, without waiting for clk.
2. sample_div=0, immediate load ftw=0x0004_0000, enable=1 -> phase 1,2,3,… one per clock; phase_valid continuously 1; value_valid follows 1 clock later (ROM_LAT=1).
3. ftw=0x4000_0000, sample_div=0 -> phase sequence 0x1000, 0x2000, 0x3000, 0x0000; wrap=1 only with 0x0000, repeating every 4 ticks.
4. sample_div=3, ftw=0x0004_0000 -> phase_valid pulses 1 clock in 4; phase increments by 1 per pulse. enable=0 for 10 clocks -> phase frozen and no pulses. Re-enable -> continues from the held value.
5. Running ftw=0x4000_0000, then sync load 0x8000_0000 when phase=0x1000 -> ftw_ready=0 until the wrap tick (phase=0x0000). The next phases are 0x2000, 0x0000 (wrap), and ftw_ready returns to 1.
6. ftw=0, poff_valid with poff_in=0x2000 -> phase becomes 0x2000 on the next tick. Then poff_in=0x3FFF with ftw=0x0004_0000 -> verify modulo-2^14 addition wraps: acc top=0x0001 gives phase=0x0000.

Source files
------------

// File: rtl/dds_phase_generator.sv
// dds_phase_generator
// Phase-accumulator front end of the DDS core. A programmable divider produces
// a sample tick; on each tick the accumulator advances by the active frequency
// tuning word (FTW). The top PHASE_W bits plus a phase offset form the
// registered ROM address. A sample strobe is delayed to line up with the ROM
// read latency.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   enable       1 = run, 0 = hold accumulator and divider
//   sample_div   tick every sample_div+1 clocks
//   ftw_in       new tuning word
//   ftw_sync     1 = apply at next accumulator wrap, 0 = apply immediately
//   ftw_valid    FTW load request
//   ftw_ready    FTW load accepted when ftw_valid & ftw_ready
//   poff_in      phase offset
//   poff_valid   latch poff_in
//   phase        ROM address (registered)
//   phase_valid  1-clock pulse when phase updates
//   value_valid  phase_valid delayed ROM_LAT clocks
//   wrap         1-clock pulse with phase_valid when the accumulator carried
module dds_phase_generator #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned PHASE_W = 14,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [DIV_W-1:0]   sample_div,
  input  logic [ACC_W-1:0]   ftw_in,
  input  logic               ftw_sync,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic [PHASE_W-1:0] poff_in,
  input  logic               poff_valid,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               value_valid,
  output logic               wrap
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } ftw_state_t;

  ftw_state_t state, state_next;

  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   ftw_active;
  logic [ACC_W-1:0]   ftw_pend;
  logic [PHASE_W-1:0] poff_active;
  logic [ACC_W:0]     acc_sum;
  logic               carry;
  logic               load_imm;
  logic               load_pend;
  logic               commit_pend;

  // Sample-rate divider; a lowered sample_div below the current count lets
  // the counter roll through 2^DIV_W before the next match.
  assign tick = enable && (div_cnt == sample_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!enable || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // One extra bit captures the carry out of the accumulator.
  assign acc_sum = {1'b0, acc} + {1'b0, ftw_active};
  assign carry   = acc_sum[ACC_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc         <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
    end else if (tick) begin
      acc         <= acc_sum[ACC_W-1:0];
      phase       <= acc_sum[ACC_W-1 -: PHASE_W] + poff_active;
      phase_valid <= 1'b1;
      wrap        <= carry;
    end else begin
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poff_active <= '0;
    end else if (poff_valid) begin
      poff_active <= poff_in;
    end
  end

  // FTW load FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FTW load FSM: next state and load controls.
  always_comb begin
    state_next  = state;
    ftw_ready   = 1'b0;
    load_imm    = 1'b0;
    load_pend   = 1'b0;
    commit_pend = 1'b0;
    case (state)
      IDLE: begin
        ftw_ready = 1'b1;
        if (ftw_valid) begin
          if (ftw_sync) begin
            load_pend  = 1'b1;
            state_next = PENDING;
          end else begin
            load_imm = 1'b1;
          end
        end
      end
      PENDING: begin
        if (tick && carry) begin
          commit_pend = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Tuning-word registers; the accumulate in the same cycle still sees the
  // old ftw_active, so a new word only affects the following tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ftw_active <= '0;
      ftw_pend   <= '0;
    end else begin
      if (load_imm) begin
        ftw_active <= ftw_in;
      end else if (commit_pend) begin
        ftw_active <= ftw_pend;
      end
      if (load_pend) begin
        ftw_pend <= ftw_in;
      end
    end
  end

  // ROM latency alignment for the sample strobe.
  generate
    if (ROM_LAT == 0) begin : g_no_lat
      assign value_valid = phase_valid;
    end else begin : g_lat
      logic [ROM_LAT-1:0] vv_pipe;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vv_pipe <= '0;
        end else begin
          vv_pipe[0] <= phase_valid;
          for (int unsigned i = 1; i < ROM_LAT; i++) begin
            vv_pipe[i] <= vv_pipe[i-1];
          end
        end
      end

      assign value_valid = vv_pipe[ROM_LAT-1];
    end
  endgenerate

endmodule

// File: tb/tb_dds_phase_generator.sv
module tb_dds_phase_generator;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] sample_div;
  logic [31:0] ftw_in;
  logic        ftw_sync;
  logic        ftw_valid;
  logic        ftw_ready;
  logic [13:0] poff_in;
  logic        poff_valid;
  logic [13:0] phase;
  logic        phase_valid;
  logic        value_valid;
  logic        wrap;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [13:0] ph;
    logic        wr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (spec-level quantities)
  longint unsigned m_acc;
  longint unsigned m_ftw;
  longint unsigned m_pend_word;
  bit              m_pending;
  int unsigned     m_poff;
  int unsigned     m_cnt;

  dds_phase_generator #(
    .ACC_W(32),
    .PHASE_W(14),
    .DIV_W(16),
    .ROM_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .sample_div(sample_div),
    .ftw_in(ftw_in),
    .ftw_sync(ftw_sync),
    .ftw_valid(ftw_valid),
    .ftw_ready(ftw_ready),
    .poff_in(poff_in),
    .poff_valid(poff_valid),
    .phase(phase),
    .phase_valid(phase_valid),
    .value_valid(value_valid),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_acc = 0;
    m_ftw = 0;
    m_pend_word = 0;
    m_pending = 0;
    m_poff = 0;
    m_cnt = 0;
  endfunction

  // Effect of one rising edge given the inputs that were presented to it.
  function automatic void model_edge(input bit en, input int unsigned sd, input bit fv,
                                     input bit fs, input longint unsigned fin,
                                     input bit pv, input int unsigned pin);
    bit              tick;
    longint unsigned sum;
    bit              carry;
    exp_t            e;
    tick  = en && (m_cnt == sd);
    carry = 0;
    if (tick) begin
      sum   = m_acc + m_ftw;
      carry = (sum >= 64'h1_0000_0000);
      m_acc = sum % 64'h1_0000_0000;
      e.cyc = cyc;
      e.ph  = 14'((m_acc / 64'h4_0000 + m_poff) % 16384);
      e.wr  = carry;
      exp_q.push_back(e);
    end
    if (!m_pending) begin
      if (fv) begin
        if (fs) begin
          m_pend_word = fin;
          m_pending = 1;
        end else begin
          m_ftw = fin;
        end
      end
    end else if (tick && carry) begin
      m_ftw = m_pend_word;
      m_pending = 0;
    end
    if (pv) m_poff = pin;
    if (!en || tick) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % 65536;
  endfunction

  task automatic step(input bit en, input int unsigned sd, input bit fv, input bit fs,
                      input longint unsigned fin, input bit pv, input int unsigned pin);
    enable     = en;
    sample_div = 16'(sd);
    ftw_valid  = fv;
    ftw_sync   = fs;
    ftw_in     = 32'(fin);
    poff_valid = pv;
    poff_in    = 14'(pin);
    @(posedge clk);
    #1;
    model_edge(en, sd, fv, fs, fin, pv, pin);
    chk("ftw_ready", ftw_ready, !m_pending);
  endtask

  task automatic idle_inputs();
    enable = 0; sample_div = 0; ftw_valid = 0; ftw_sync = 0;
    ftw_in = 0; poff_valid = 0; poff_in = 0;
  endtask

  // Asynchronous reset between edges; outputs checked before any clock.
  task automatic do_reset();
    idle_inputs();
    #2;
    rst = 0;
    #1;
    chk("rst_phase", phase, 0);
    chk("rst_phase_valid", phase_valid, 0);
    chk("rst_value_valid", value_valid, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_ftw_ready", ftw_ready, 1);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #2;
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected samples whenever the DUT should/does strobe.
  bit exp_prev = 0;
  always @(negedge clk) begin
    bit   cur;
    exp_t e;
    if (!rst) begin
      exp_prev = 0;
    end else begin
      cur = 0;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL stale_expect: got none, expected phase %0h at cycle %0d", e.ph, e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        cur = 1;
        chk("phase_valid", phase_valid, 1);
        chk("phase", phase, e.ph);
        chk("wrap", wrap, e.wr);
      end else begin
        chk("no_phase_valid", phase_valid, 0);
        chk("no_wrap", wrap, 0);
      end
      chk("value_valid", value_valid, exp_prev);
      exp_prev = cur;
    end
  end

  initial begin
    int unsigned sd;
    longint unsigned f;
    rst = 0;
    idle_inputs();
    model_reset();
    #12;
    chk("init_phase", phase, 0);
    chk("init_phase_valid", phase_valid, 0);
    chk("init_value_valid", value_valid, 0);
    chk("init_wrap", wrap, 0);
    chk("init_ftw_ready", ftw_ready, 1);
    rst = 1;
    @(posedge clk);
    #1;

    // Immediate load, tick every clock
    step(1, 0, 1, 0, 32'h0004_0000, 0, 0);
    repeat (10) step(1, 0, 0, 0, 0, 0, 0);

    // Quarter-turn word: 0x1000,0x2000,0x3000,0x0000 with wrap
    do_reset();
    step(1, 0, 1, 0, 32'h4000_0000, 0, 0);
    repeat (12) step(1, 0, 0, 0, 0, 0, 0);

    // Divider of 4 plus a hold period
    do_reset();
    step(1, 3, 1, 0, 32'h0004_0000, 0, 0);
    repeat (20) step(1, 3, 0, 0, 0, 0, 0);
    repeat (10) step(0, 3, 0, 0, 0, 0, 0);
    repeat (20) step(1, 3, 0, 0, 0, 0, 0);

    // Phase-continuous load deferred to the wrap
    do_reset();
    step(1, 0, 1, 0, 32'h4000_0000, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 32'h8000_0000, 0, 0);
    repeat (8) step(1, 0, 0, 0, 0, 0, 0);

    // Phase offset, then modulo wrap of offset addition
    do_reset();
    step(1, 0, 0, 0, 0, 1, 14'h2000);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 32'h0004_0000, 1, 14'h3FFF);
    repeat (5) step(1, 0, 0, 0, 0, 0, 0);

    // Pending load retained across hold, then cleared by a mid-run reset
    do_reset();
    step(1, 0, 1, 0, 32'h0010_0000, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 32'h4000_0000, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    do_reset();
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    sd = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) sd = m_cnt + $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: f = $urandom;
        1: f = $urandom >> 8;
        2: f = 64'h4000_0000;
        default: f = longint'($urandom_range(0, 15)) << 18;
      endcase
      step($urandom_range(0, 9) != 0, sd, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, f, $urandom_range(0, 19) == 0,
           $urandom_range(0, 16383));
    end

    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
